mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit feeding the HI and LO registers of the multi-cycle MIPS datapath. It sits directly downstream of `control_unit`, which starts it with a one-cycle `MultCtrl` or `DivCtrl` pulse. The control unit then waits on `done`, or branches to its divide-by-zero exception states on `div_zero`. The unit owns the HI/LO results and keeps them stable until the next operation completes.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/mult_div_unit_if.sv | 28 ++
 rtl/mult_div_unit.sv | 132 +++++++++++++
 tb/tb_mult_div_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the multi-cycle MIPS core.
package cpu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_RUN,
    MD_FIX,
    MD_DONE
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/operand/result bundle between control_unit (master) and mult_div_unit (slave).
interface mult_div_unit_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output mult_start, div_start, a, b,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, a, b,
    output hi, lo, busy, done, div_zero
  );

endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (shift-add) / divide (restoring) unit owning HI/LO.
// One iteration per cycle on operand magnitudes, sign fix-up in a final cycle.
module mult_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_div_unit_if.slave       bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_remd;

  // The most-negative operand maps onto itself, which is still its correct unsigned magnitude.
  assign w_mag_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign w_mag_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

  // Multiply: low half of r_acc holds the remaining multiplier bits, upper half the running sum.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};

  // Divide: low half of r_acc shifts dividend bits out and quotient bits in.
  assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_opnd};

  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quot = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remd = r_neg_hi ? -r_rem : r_rem;

  // NOTE: only control state and visible outputs are reset; the datapath registers are
  // always reloaded on an accepted start before they are read.
  // NOTE: every register here is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= MD_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (bus.mult_start) begin
            r_state  <= MD_RUN;
            r_busy   <= 1'b1;
            r_is_div <= 1'b0;
            r_neg_lo <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            r_opnd   <= w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt    <= '0;
          end else if (bus.div_start) begin
            r_busy <= 1'b1;
            if (bus.b == '0) begin
              r_state    <= MD_DONE;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state  <= MD_RUN;
              r_is_div <= 1'b1;
              r_neg_lo <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              r_neg_hi <= bus.a[WIDTH-1];
              r_opnd   <= w_mag_b;
              r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
              r_rem    <= '0;
              r_cnt    <= '0;
            end
          end
        end
        MD_RUN: begin
          if (r_is_div) begin
            r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], ~w_div_trial[WIDTH]};
            // A kept (non-negative) trial is always below the divisor, so it fits WIDTH bits.
            r_rem <= w_div_trial[WIDTH] ? w_div_shift[WIDTH-1:0] : w_div_trial[WIDTH-1:0];
          end else begin
            r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= MD_FIX;
        end
        MD_FIX: begin
          if (r_is_div) begin
            r_hi <= w_remd;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= MD_DONE;
        end
        MD_DONE: begin
          r_busy  <= 1'b0;
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // HI/LO result from signed 64-bit arithmetic; divide by zero leaves HI/LO untouched.
  function automatic void model(input bit mul, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output bit dz);
    longint sa, sb, r64;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    if (mul) begin
      r64 = sa * sb;
      hi  = r64[63:32];
      lo  = r64[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
      hi = m_hi;
      lo = m_lo;
    end else begin
      r64 = sa / sb;
      lo  = r64[31:0];
      r64 = sa % sb;
      hi  = r64[31:0];
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Starts an operation at the next edge and follows it to completion.
  // disturb: scramble a/b and pulse both starts mid-run; poke_done: raise a start during DONE.
  task automatic run_op(input bit mul, input bit both, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit disturb, input bit poke_done);
    logic [W-1:0] e_hi, e_lo, p_hi, p_lo;
    bit           e_dz, seen;
    int           cyc, busy_gaps, early;
    model(mul || both, a, b, e_hi, e_lo, e_dz);
    p_hi = m_hi;
    p_lo = m_lo;
    bus.a          = a;
    bus.b          = b;
    bus.mult_start = mul || both;
    bus.div_start  = !mul || both;
    @(posedge clk);
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    if (disturb) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
    end
    cyc = 0; busy_gaps = 0; early = 0;
    seen = bus.done;
    while (!seen && cyc < 3 * LATENCY) begin
      if (bus.busy !== 1'b1) busy_gaps++;
      if (bus.hi !== p_hi || bus.lo !== p_lo || bus.div_zero !== 1'b0) early++;
      if (disturb && cyc == 5) begin
        bus.mult_start = 1'b1;
        bus.div_start  = 1'b1;
        bus.b          = '0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      bus.mult_start = 1'b0;
      bus.div_start  = 1'b0;
      seen = bus.done;
    end
    check("latency", 64'(cyc), e_dz ? 64'd0 : 64'(LATENCY));
    check("busy_during_run", 64'(busy_gaps), 64'd0);
    check("hilo_stable_before_done", 64'(early), 64'd0);
    check("done_hi", 64'(bus.hi), 64'(e_hi));
    check("done_lo", 64'(bus.lo), 64'(e_lo));
    check("done_div_zero", 64'(bus.div_zero), 64'(e_dz));
    check("done_busy", 64'(bus.busy), 64'd1);
    m_hi = e_hi;
    m_lo = e_lo;
    if (poke_done) bus.mult_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.mult_start = 1'b0;
    check("after_done_pulse", 64'(bus.done), 64'd0);
    check("after_done_busy", 64'(bus.busy), 64'd0);
    check("after_done_hi", 64'(bus.hi), 64'(m_hi));
    check("after_done_lo", 64'(bus.lo), 64'(m_lo));
  endtask

  task automatic reset_midrun();
    int done_cnt;
    bus.a         = W'($urandom);
    bus.b         = W'($urandom) | 32'h1;
    bus.div_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.div_start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        bus.div_start  = 1'b1;
        bus.mult_start = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      bus.div_start  = 1'b0;
      bus.mult_start = 1'b0;
    end
    check("busy_before_reset", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_busy", 64'(bus.busy), 64'd0);
    check("midrun_reset_hi", 64'(bus.hi), 64'd0);
    check("midrun_reset_lo", 64'(bus.lo), 64'd0);
    done_cnt = 0;
    repeat (2 * LATENCY) begin
      @(posedge clk);
      @(negedge clk);
      done_cnt += int'(bus.done);
    end
    check("no_done_after_reset", 64'(done_cnt), 64'd0);
    m_hi = '0;
    m_lo = '0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.mult_start = 1'b0;
    bus.div_start  = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_div_zero", 64'(bus.div_zero), 64'd0);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b1);
    run_op(1'b0, 1'b0, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra, rb;
      ra = pick();
      rb = ($urandom_range(0, 5) == 0) ? '0 : pick();
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), ra, rb,
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
    end

    reset_midrun();
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
